// File: rtl/dmem_responder.sv
// Byte-addressed data memory responder with programmable wait states and a single outstanding access.
// Optional per-byte parity storage and checking is built when DMEM_PARITY_EN is defined.
module dmem_responder #(
    parameter int DWIDTH = 8,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [DWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              inj_perr,
    output logic              ack,
    output logic [DWIDTH-1:0] rdata,
    output logic              busy,
    output logic              perr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam int         DEPTH    = 1 << DWIDTH;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                weLat_q;
    logic [DWIDTH-1:0]   addrLat_q;
    logic [DWIDTH-1:0]   wdataLat_q;
    logic                ack_q;
    logic [DWIDTH-1:0]   rdata_q;
    logic [DWIDTH-1:0]   mem_q [DEPTH];

    logic                accEn;
    logic                accWe;
    logic [DWIDTH-1:0]   accAddr;
    logic [DWIDTH-1:0]   accWdata;

`ifdef DMEM_PARITY_EN
    logic                injLat_q;
    logic                accInj;
    logic                perr_q;
    logic                par_q [DEPTH];
`else
    logic                unusedInj;
    assign unusedInj = inj_perr;
`endif

    // Sequencer: IDLE samples a request, WAIT counts down, ACK pulses for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            weLat_q    <= 1'b0;
            addrLat_q  <= '0;
            wdataLat_q <= '0;
            ack_q      <= 1'b0;
`ifdef DMEM_PARITY_EN
            injLat_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        weLat_q    <= we;
                        addrLat_q  <= addr;
                        wdataLat_q <= wdata;
`ifdef DMEM_PARITY_EN
                        injLat_q   <= inj_perr;
`endif
                        cnt_q      <= WAIT_CNT;
                        if (WAIT_CNT == 4'd0) begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // With zero wait states the access happens on the sampling edge, so it uses the live inputs.
    always_comb begin
        accEn    = 1'b0;
        accWe    = weLat_q;
        accAddr  = addrLat_q;
        accWdata = wdataLat_q;
`ifdef DMEM_PARITY_EN
        accInj   = injLat_q;
`endif
        if (state_q == S_IDLE) begin
            accEn    = req && (WAIT_CNT == 4'd0);
            accWe    = we;
            accAddr  = addr;
            accWdata = wdata;
`ifdef DMEM_PARITY_EN
            accInj   = inj_perr;
`endif
        end else if (state_q == S_WAIT) begin
            accEn = (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else if (accEn) begin
            if (accWe) begin
                mem_q[accAddr] <= accWdata;
            end else begin
                rdata_q <= mem_q[accAddr];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    // The perr flag defaults low every edge so it can only be high during ACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= 1'b0;
            end
            perr_q <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            if (accEn) begin
                if (accWe) begin
                    par_q[accAddr] <= (^accWdata) ^ accInj;
                end else begin
                    perr_q <= ((^mem_q[accAddr]) != par_q[accAddr]);
                end
            end
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != S_IDLE);

endmodule
